// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 16x-oversampling UART receiver.
//
// The raw rx line is synchronised, and the receiver then waits for a
// high-to-low start edge. Each bit is sampled on ticks 7, 8 and 9 of its
// 16-tick window, and the bit value is the 2-of-3 majority. Data arrives
// LSB first. An optional parity bit and the stop bit are checked, and each
// frame produces a one-clock rx_valid pulse.
//
// Parameters
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = even, 2 = odd
//
// Ports
//   clk         in   system clock
//   reset_n     in   async active-low reset
//   tick_16x    in   one-clock strobe at 16x the baud rate
//   rx          in   raw serial line (asynchronous, idle high)
//   rx_data     out  received word, LSB = first bit on the line
//   rx_valid    out  one-clock pulse: rx_data and error flags are valid
//   frame_err   out  stop bit sampled low; qualified by rx_valid
//   parity_err  out  parity mismatch; qualified by rx_valid (0 if PARITY=0)
//   rx_busy     out  receiver is in any state other than IDLE
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a high->low edge on the synchronised line
// S_START | validating the start bit (glitch rejection at tick 9)
// S_DATA  | shifting in DATA_BITS data bits
// S_PAR   | capturing the parity bit (only reached when PARITY != 0)
// S_STOP  | resolving the stop bit; leaves at tick 9 to catch the next edge
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_16x,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [3:0]           cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 samp7;
  logic                 samp8;

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_s_d;

  logic                 maj;
  logic                 start_edge;
  logic                 parity_bad;

  // Two-flop synchroniser plus one delay stage for edge detection.
  // These flops reset to 1 so the idle line does not look like a start edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign start_edge = rx_s_d & ~rx_s;

  // Majority vote. The third sample is the live synchronised line on the
  // cnt==9 tick.
  assign maj = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);

  // Parity check of the completed word against the captured parity bit.
  always_comb begin
    parity_bad = 1'b0;
    if (PARITY == 1) begin
      parity_bad = (^{shift_reg, par_bit}) != 1'b0;
    end else if (PARITY == 2) begin
      parity_bad = (^{shift_reg, par_bit}) != 1'b1;
    end
  end

  assign rx_busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      bit_idx    <= 4'd0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      samp7      <= 1'b1;
      samp8      <= 1'b1;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (state == S_IDLE) begin
        // The edge is taken on any clock, not only on a tick, so the tick
        // phase jitter stays within one tick.
        if (start_edge) begin
          state   <= S_START;
          cnt     <= 4'd0;
          bit_idx <= 4'd0;
        end
      end else if (tick_16x) begin
        cnt <= cnt + 4'd1;
        if (cnt == 4'd7) samp7 <= rx_s;
        if (cnt == 4'd8) samp8 <= rx_s;

        case (state)
          S_START: begin
            if (cnt == 4'd9 && maj) begin
              state <= S_IDLE;
              cnt   <= 4'd0;
            end else if (cnt == 4'd15) begin
              state <= S_DATA;
            end
          end

          S_DATA: begin
            if (cnt == 4'd9) begin
              shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
            end
            if (cnt == 4'd15) begin
              if (bit_idx == LAST_BIT) begin
                state <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
          end

          S_PAR: begin
            if (cnt == 4'd9) par_bit <= maj;
            if (cnt == 4'd15) state <= S_STOP;
          end

          S_STOP: begin
            if (cnt == 4'd9) begin
              state      <= S_IDLE;
              cnt        <= 4'd0;
              rx_data    <= shift_reg;
              rx_valid   <= 1'b1;
              frame_err  <= ~maj;
              parity_err <= parity_bad;
            end
          end

          default: begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx.
//
// Two instances are used. dut_a has no parity and dut_b has even parity.
// Each has its own serial line. Stimulus pushes the expected
// {data, frame_err, parity_err} into a per-instance queue. Independent
// monitors pop the queue and compare on every rx_valid pulse.
// tick_16x fires every 4 clocks, so one bit lasts 64 clocks.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tick_16x = 1'b0;
  logic       rx_a     = 1'b1;
  logic       rx_b     = 1'b1;

  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       fe_a, fe_b;
  logic       pe_a, pe_b;
  logic       busy_a, busy_b;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  uart_rx #(.DATA_BITS(8), .PARITY(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick_16x), .rx(rx_a),
    .rx_data(data_a), .rx_valid(valid_a), .frame_err(fe_a),
    .parity_err(pe_a), .rx_busy(busy_a)
  );

  uart_rx #(.DATA_BITS(8), .PARITY(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick_16x(tick_16x), .rx(rx_b),
    .rx_data(data_b), .rx_valid(valid_b), .frame_err(fe_b),
    .parity_err(pe_b), .rx_busy(busy_b)
  );

  always #5 clk = ~clk;

  initial begin
    int tcnt;
    tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      tcnt     = (tcnt + 1) % 4;
      tick_16x = (tcnt == 0);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_pulse actual=rx_valid=1 required=no pulse at %0t", $time);
        end else begin
          e = q_a.pop_front();
          chk("a_rx_data", data_a, e.d);
          chk("a_frame_err", 8'(fe_a), 8'(e.fe));
          chk("a_parity_err", 8'(pe_a), 8'(e.pe));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_pulse actual=rx_valid=1 required=no pulse at %0t", $time);
        end else begin
          e = q_b.pop_front();
          chk("b_rx_data", data_b, e.d);
          chk("b_frame_err", 8'(fe_b), 8'(e.fe));
          chk("b_parity_err", 8'(pe_b), 8'(e.pe));
        end
      end
    end
  end

  task automatic bit_out(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (64) @(posedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                      input logic p, input logic stop);
    bit_out(sel, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(sel, d[i]);
    if (has_par) bit_out(sel, p);
    bit_out(sel, stop);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * 64) @(posedge clk);
  endtask

  initial begin
    logic [7:0] abort_d;

    // Reset state
    #1;
    chk("reset_a_data", data_a, 8'h00);
    chk("reset_a_valid", 8'(valid_a), 8'h0);
    chk("reset_a_busy", 8'(busy_a), 8'h0);
    chk("reset_a_fe", 8'(fe_a), 8'h0);
    chk("reset_b_pe", 8'(pe_b), 8'h0);
    repeat (10) @(posedge clk);
    reset_n = 1'b1;
    idle_bits(2);

    // 1: plain 8N1 frame
    q_a.push_back('{8'hA5, 1'b0, 1'b0});
    send(0, 8'hA5, 0, 1'b0, 1'b1);
    idle_bits(2);

    // 2: 3-tick glitch is rejected, then a good frame
    rx_a = 1'b0;
    repeat (12) @(posedge clk);
    rx_a = 1'b1;
    #1;
    chk("glitch_busy_during", 8'(busy_a), 8'h1);
    repeat (80) @(posedge clk);
    #1;
    chk("glitch_busy_after", 8'(busy_a), 8'h0);
    idle_bits(1);
    q_a.push_back('{8'h3C, 1'b0, 1'b0});
    send(0, 8'h3C, 0, 1'b0, 1'b1);
    idle_bits(2);

    // 3: framing error, line stuck low, then recovery
    q_a.push_back('{8'hFF, 1'b1, 1'b0});
    send(0, 8'hFF, 0, 1'b0, 1'b0);
    repeat (20 * 64) @(posedge clk);
    #1;
    chk("stuck_low_busy", 8'(busy_a), 8'h0);
    rx_a = 1'b1;
    idle_bits(2);
    q_a.push_back('{8'h11, 1'b0, 1'b0});
    send(0, 8'h11, 0, 1'b0, 1'b1);
    idle_bits(2);

    // 4: even parity on dut_b. 0x07 has three ones, so the correct bit is 1.
    q_b.push_back('{8'h07, 1'b0, 1'b1});
    send(1, 8'h07, 1, 1'b0, 1'b1);
    idle_bits(1);
    q_b.push_back('{8'h07, 1'b0, 1'b0});
    send(1, 8'h07, 1, 1'b1, 1'b1);
    idle_bits(2);

    // 5: reset during data bit 4 aborts the frame
    abort_d = 8'h5A;
    bit_out(0, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(0, abort_d[i]);
    rx_a = abort_d[4];
    repeat (32) @(posedge clk);
    #1;
    chk("abort_busy_before", 8'(busy_a), 8'h1);
    reset_n = 1'b0;
    #1;
    chk("abort_a_data", data_a, 8'h00);
    chk("abort_a_busy", 8'(busy_a), 8'h0);
    chk("abort_a_valid", 8'(valid_a), 8'h0);
    chk("abort_b_data", data_b, 8'h00);
    rx_a = 1'b1;
    repeat (20) @(posedge clk);
    reset_n = 1'b1;
    idle_bits(2);
    q_a.push_back('{8'h5A, 1'b0, 1'b0});
    send(0, 8'h5A, 0, 1'b0, 1'b1);
    idle_bits(2);

    // 6: back-to-back frames, no idle gap
    q_a.push_back('{8'h00, 1'b0, 1'b0});
    q_a.push_back('{8'hFF, 1'b0, 1'b0});
    send(0, 8'h00, 0, 1'b0, 1'b1);
    send(0, 8'hFF, 0, 1'b0, 1'b1);
    idle_bits(2);

    // Every expected pulse must have been seen
    chk("a_pending", 8'(q_a.size()), 8'h00);
    chk("b_pending", 8'(q_b.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
